// File: rtl/smi_line_rx.sv
// ---------------------------------------------------------------------------
// smi_line_rx
//
// Receives LED line data from a host over an asynchronous SMI write strobe
// and stores it byte by byte into a small multi-line buffer RAM. Complete
// lines are queued for a downstream TLC stage, which releases them one at a
// time with line_pop_i. A frame-start opto pulse restarts the line count of
// the current frame and discards any partially received line.
//
// Ports
//   clk_i         system clock (single clock domain)
//   global_rst_n  asynchronous active-low reset
//   frame_opto_i  asynchronous frame-start pulse
//   smi_nwe_i     asynchronous SMI write strobe, active-low
//   smi_data_i    SMI data byte, stable while smi_nwe_i is low
//   line_pop_i    one-cycle pulse: oldest buffered line has been consumed
//   ram_we_o      buffer RAM write enable, one cycle per byte
//   ram_waddr_o   buffer RAM write address {wr_line, byte_idx}
//   ram_wdata_o   byte to write
//   line_valid_o  at least one complete line is buffered
//   rd_line_o     slot index of the oldest complete line
//   busy_o        buffer full, host must hold off
//   frame_rst_o   a new frame has started, host restarts its line count
//   frame_line_o  lines committed in the current frame
//   ovf_o         sticky flag: a byte was dropped
// ---------------------------------------------------------------------------
module smi_line_rx #(
  parameter  int LEDS       = 48,
  parameter  int FIFO_LINES = 4,
  parameter  int LINES      = 240,
  localparam int BW         = $clog2(LEDS * 4),
  localparam int LW         = $clog2(FIFO_LINES),
  localparam int FW         = $clog2(LINES + 1)
) (
  input  logic               clk_i,
  input  logic               global_rst_n,
  input  logic               frame_opto_i,
  input  logic               smi_nwe_i,
  input  logic [7:0]         smi_data_i,
  input  logic               line_pop_i,
  output logic               ram_we_o,
  output logic [LW+BW-1:0]   ram_waddr_o,
  output logic [7:0]         ram_wdata_o,
  output logic               line_valid_o,
  output logic [LW-1:0]      rd_line_o,
  output logic               busy_o,
  output logic               frame_rst_o,
  output logic [FW-1:0]      frame_line_o,
  output logic               ovf_o
);

  logic          nwe_s1, nwe_s2, nwe_s3;
  logic          opto_s1, opto_s2, opto_s3;
  logic [7:0]    data_q;

  logic [BW-1:0] byte_idx;
  logic [LW-1:0] wr_line;
  logic [LW-1:0] rd_line;
  logic [LW:0]   count;
  logic [FW-1:0] frame_line;

  logic          write_ev;
  logic          frame_ev;
  logic          fifo_full;
  logic [BW-1:0] byte_eff;
  logic [FW-1:0] frame_line_eff;
  logic          accept;
  logic          drop;
  logic          commit;
  logic          pop_ok;
  logic [LW:0]   count_next;

  // Both asynchronous inputs get a three-flop chain; the write strobe idles
  // high so its chain resets to 1, which guarantees no write event is seen
  // until the host produces a real low-to-high sequence after reset.
  always_ff @(posedge clk_i or negedge global_rst_n) begin
    if (!global_rst_n) begin
      nwe_s1  <= 1'b1;
      nwe_s2  <= 1'b1;
      nwe_s3  <= 1'b1;
      opto_s1 <= 1'b0;
      opto_s2 <= 1'b0;
      opto_s3 <= 1'b0;
    end else begin
      nwe_s1  <= smi_nwe_i;
      nwe_s2  <= nwe_s1;
      nwe_s3  <= nwe_s2;
      opto_s1 <= frame_opto_i;
      opto_s2 <= opto_s1;
      opto_s3 <= opto_s2;
    end
  end

  // Data is captured while the first synchronizer stage still sees the
  // strobe low; by the time the rising edge reaches s2/s3 this register
  // holds the last byte sampled during the low phase.
  always_ff @(posedge clk_i or negedge global_rst_n) begin
    if (!global_rst_n) begin
      data_q <= '0;
    end else if (!nwe_s1) begin
      data_q <= smi_data_i;
    end
  end

  // A frame edge is applied before a coincident write, so the write sees
  // byte index 0 and an empty frame line count.
  always_comb begin
    write_ev       = nwe_s2 & ~nwe_s3;
    frame_ev       = opto_s2 & ~opto_s3;
    fifo_full      = (count == (LW+1)'(FIFO_LINES));
    byte_eff       = frame_ev ? '0 : byte_idx;
    frame_line_eff = frame_ev ? '0 : frame_line;
    accept         = write_ev && !fifo_full && (frame_line_eff != FW'(LINES));
    drop           = write_ev && !accept;
    commit         = accept && (byte_eff == BW'(LEDS * 4 - 1));
    pop_ok         = line_pop_i && (count != '0);
  end

  always_comb begin
    count_next = count;
    if (commit && !pop_ok) begin
      count_next = count + (LW+1)'(1);
    end else if (!commit && pop_ok) begin
      count_next = count - (LW+1)'(1);
    end
  end

  // Write-side pointers and frame bookkeeping.
  always_ff @(posedge clk_i or negedge global_rst_n) begin
    if (!global_rst_n) begin
      byte_idx   <= '0;
      wr_line    <= '0;
      frame_line <= '0;
    end else begin
      byte_idx   <= byte_eff;
      frame_line <= frame_line_eff;
      if (commit) begin
        byte_idx <= '0;
        wr_line  <= wr_line + LW'(1);
        if (frame_line_eff != FW'(LINES)) begin
          frame_line <= frame_line_eff + FW'(1);
        end
      end else if (accept) begin
        byte_idx <= byte_eff + BW'(1);
      end
    end
  end

  // Read side: occupancy and oldest-line pointer. busy_o is derived from the
  // next count so it lines up with the count register itself.
  always_ff @(posedge clk_i or negedge global_rst_n) begin
    if (!global_rst_n) begin
      count   <= '0;
      rd_line <= '0;
      busy_o  <= 1'b0;
    end else begin
      count  <= count_next;
      busy_o <= (count_next == (LW+1)'(FIFO_LINES));
      if (pop_ok) begin
        rd_line <= rd_line + LW'(1);
      end
    end
  end

  // RAM write port and host-facing status flags. A drop in the same cycle
  // as a frame edge still leaves ovf_o set, since the edge is applied first.
  always_ff @(posedge clk_i or negedge global_rst_n) begin
    if (!global_rst_n) begin
      ram_we_o    <= 1'b0;
      ram_waddr_o <= '0;
      ram_wdata_o <= '0;
      ovf_o       <= 1'b0;
      frame_rst_o <= 1'b1;
    end else begin
      ram_we_o <= accept;
      if (accept) begin
        ram_waddr_o <= {wr_line, byte_eff};
        ram_wdata_o <= data_q;
      end
      if (frame_ev) begin
        ovf_o <= 1'b0;
      end
      if (drop) begin
        ovf_o <= 1'b1;
      end
      if (accept) begin
        frame_rst_o <= 1'b0;
      end else if (frame_ev) begin
        frame_rst_o <= 1'b1;
      end
    end
  end

  assign line_valid_o = (count != '0);
  assign rd_line_o    = rd_line;
  assign frame_line_o = frame_line;

endmodule

// File: tb/tb_smi_line_rx.sv
// ---------------------------------------------------------------------------
// tb_smi_line_rx
//
// Self-checking bench for smi_line_rx. A small behavioural model of the line
// buffer decides, for each host byte, whether it should be written and at
// which address; accepted bytes are pushed to a scoreboard queue and popped
// by a monitor whenever the DUT pulses ram_we_o.
// ---------------------------------------------------------------------------
module tb_smi_line_rx;

  localparam int LEDS       = 48;
  localparam int FIFO_LINES = 4;
  localparam int LINES      = 240;
  localparam int LINE_BYTES = LEDS * 4;
  localparam int BW         = $clog2(LINE_BYTES);
  localparam int LW         = $clog2(FIFO_LINES);
  localparam int FW         = $clog2(LINES + 1);

  logic               clk_i = 1'b0;
  logic               global_rst_n;
  logic               frame_opto_i;
  logic               smi_nwe_i;
  logic [7:0]         smi_data_i;
  logic               line_pop_i;
  logic               ram_we_o;
  logic [LW+BW-1:0]   ram_waddr_o;
  logic [7:0]         ram_wdata_o;
  logic               line_valid_o;
  logic [LW-1:0]      rd_line_o;
  logic               busy_o;
  logic               frame_rst_o;
  logic [FW-1:0]      frame_line_o;
  logic               ovf_o;

  int assertions = 0;
  int failures   = 0;

  logic [LW+BW+7:0] sb_q[$];

  int m_wr_line, m_byte, m_count, m_rd_line, m_frame_line;
  bit m_ovf, m_frame_rst;

  smi_line_rx #(
    .LEDS(LEDS), .FIFO_LINES(FIFO_LINES), .LINES(LINES)
  ) dut (
    .clk_i(clk_i),
    .global_rst_n(global_rst_n),
    .frame_opto_i(frame_opto_i),
    .smi_nwe_i(smi_nwe_i),
    .smi_data_i(smi_data_i),
    .line_pop_i(line_pop_i),
    .ram_we_o(ram_we_o),
    .ram_waddr_o(ram_waddr_o),
    .ram_wdata_o(ram_wdata_o),
    .line_valid_o(line_valid_o),
    .rd_line_o(rd_line_o),
    .busy_o(busy_o),
    .frame_rst_o(frame_rst_o),
    .frame_line_o(frame_line_o),
    .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_i) begin
    if (global_rst_n && ram_we_o) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_we", 32'(ram_waddr_o), 32'hFFFF_FFFF);
      end else begin
        logic [LW+BW+7:0] exp_entry;
        exp_entry = sb_q.pop_front();
        checkOutput("we_addr", 32'(ram_waddr_o), 32'(exp_entry[LW+BW+7:8]));
        checkOutput("we_data", 32'(ram_wdata_o), 32'(exp_entry[7:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    m_wr_line = 0; m_byte = 0; m_count = 0; m_rd_line = 0;
    m_frame_line = 0; m_ovf = 0; m_frame_rst = 1;
  endfunction

  function automatic void model_write(input logic [7:0] d);
    logic [LW+BW-1:0] addr;
    if (m_count == FIFO_LINES || m_frame_line == LINES) begin
      m_ovf = 1;
      return;
    end
    addr = {LW'(m_wr_line), BW'(m_byte)};
    sb_q.push_back({addr, d});
    m_frame_rst = 0;
    if (m_byte == LINE_BYTES - 1) begin
      m_byte = 0;
      m_wr_line = (m_wr_line + 1) % FIFO_LINES;
      m_count++;
      if (m_frame_line < LINES) m_frame_line++;
    end else begin
      m_byte++;
    end
  endfunction

  function automatic void model_pop();
    if (m_count != 0) begin
      m_count--;
      m_rd_line = (m_rd_line + 1) % FIFO_LINES;
    end
  endfunction

  // One host write; optionally pulses line_pop_i in the exact cycle the
  // write event is registered by the DUT (third clock edge after the rise).
  task automatic applyStimulus(input logic [7:0] d, input bit pop_at_event = 0);
    model_write(d);
    @(negedge clk_i);
    smi_data_i = d;
    smi_nwe_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    smi_nwe_i = 1'b1;
    if (pop_at_event) begin
      model_pop();
      repeat (2) @(negedge clk_i);
      line_pop_i = 1'b1;
      @(negedge clk_i);
      line_pop_i = 1'b0;
      @(negedge clk_i);
    end else begin
      repeat (4) @(negedge clk_i);
    end
  endtask

  task automatic popLine();
    model_pop();
    @(negedge clk_i);
    line_pop_i = 1'b1;
    @(negedge clk_i);
    line_pop_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic framePulse();
    m_byte = 0; m_frame_line = 0; m_ovf = 0; m_frame_rst = 1;
    @(negedge clk_i);
    frame_opto_i = 1'b1;
    repeat (3) @(negedge clk_i);
    frame_opto_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".line_valid"}, 32'(line_valid_o), 32'(m_count != 0));
    checkOutput({tag, ".rd_line"},    32'(rd_line_o),    32'(m_rd_line));
    checkOutput({tag, ".busy"},       32'(busy_o),       32'(m_count == FIFO_LINES));
    checkOutput({tag, ".frame_rst"},  32'(frame_rst_o),  32'(m_frame_rst));
    checkOutput({tag, ".frame_line"}, 32'(frame_line_o), 32'(m_frame_line));
    checkOutput({tag, ".ovf"},        32'(ovf_o),        32'(m_ovf));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".we"},         32'(ram_we_o),     32'd0);
    checkOutput({tag, ".waddr"},      32'(ram_waddr_o),  32'd0);
    checkOutput({tag, ".wdata"},      32'(ram_wdata_o),  32'd0);
    checkOutput({tag, ".line_valid"}, 32'(line_valid_o), 32'd0);
    checkOutput({tag, ".rd_line"},    32'(rd_line_o),    32'd0);
    checkOutput({tag, ".busy"},       32'(busy_o),       32'd0);
    checkOutput({tag, ".frame_rst"},  32'(frame_rst_o),  32'd1);
    checkOutput({tag, ".frame_line"}, 32'(frame_line_o), 32'd0);
    checkOutput({tag, ".ovf"},        32'(ovf_o),        32'd0);
  endtask

  initial begin
    global_rst_n = 1'b0;
    frame_opto_i = 1'b0;
    smi_nwe_i    = 1'b1;
    smi_data_i   = 8'h00;
    line_pop_i   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    checkResetOutputs("reset");
    global_rst_n = 1'b1;
    repeat (3) @(negedge clk_i);
    checkState("post_reset");

    // First line: bytes 0x01..0xC0 at addresses 0x000..0x0BF.
    for (int i = 0; i < LINE_BYTES; i++) begin
      applyStimulus(8'(i + 1));
      if (i == 0) checkOutput("frame_rst_after_byte1", 32'(frame_rst_o), 32'd0);
    end
    checkState("line1");

    // Three more lines fill the buffer; a further byte must be dropped.
    for (int l = 1; l < FIFO_LINES; l++) begin
      for (int i = 0; i < LINE_BYTES; i++) applyStimulus(8'((i * 7 + l * 13) & 8'hFF));
    end
    checkState("full");
    applyStimulus(8'hA5);
    checkState("drop");

    // Freeing one slot lets writing resume at slot 0, byte 0.
    popLine();
    checkState("pop1");
    for (int i = 0; i < 100; i++) applyStimulus(8'(8'h40 ^ i));
    checkState("partial100");

    // Frame edge discards the partial line but keeps committed lines.
    framePulse();
    checkState("frame_edge");
    applyStimulus(8'h5A);
    checkState("after_frame");

    // Commit coinciding with a pop at count 2.
    popLine();
    checkState("pop2");
    for (int i = 1; i < LINE_BYTES - 1; i++) applyStimulus(8'(i ^ 8'h3C));
    applyStimulus(8'hEE, 1'b1);
    checkState("commit_pop");
    applyStimulus(8'h77);
    popLine();
    popLine();
    checkState("drained");

    // Reset in the middle of a line.
    for (int i = 0; i < 50; i++) applyStimulus(8'(i + 8'h80));
    checkOutput("sb_before_reset", 32'(sb_q.size()), 32'd0);
    @(negedge clk_i);
    #2 global_rst_n = 1'b0;
    #1 checkResetOutputs("mid_reset");
    model_reset();
    repeat (3) @(negedge clk_i);
    global_rst_n = 1'b1;
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'hC0 + i));
    checkState("after_mid_reset");

    repeat (5) @(negedge clk_i);
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/smi_line_rx.md
SMI_LINE_RX -- requirements
Module: smi_line_rx

Interface
REQ-001 Parameter LEDS, default 48: LEDs per line; line length is LEDS*4 bytes.
REQ-002 Parameter FIFO_LINES, default 4: line slots in the write buffer; power of two.
REQ-003 Parameter LINES, default 240: lines per frame.
REQ-004 Derived widths: BW = clog2(LEDS*4) (8); LW = clog2(FIFO_LINES) (2); FW = clog2(LINES+1) (8).
REQ-005 clk_i  in  1  system clock; single clock domain.
REQ-006 global_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_opto_i  in  1  asynchronous opto pulse marking frame start.
REQ-008 smi_nwe_i  in  1  asynchronous SMI write strobe, active-low.
REQ-009 smi_data_i  in  8  SMI data, stable while smi_nwe_i is low.
REQ-010 line_pop_i  in  1  one-cycle pulse from the TLC stage: oldest line consumed.
REQ-011 ram_we_o  out  1  buffer RAM write enable, one cycle per byte.
REQ-012 ram_waddr_o  out  LW+BW  RAM write address {wr_line, byte_idx}.
REQ-013 ram_wdata_o  out  8  byte to write.
REQ-014 line_valid_o  out  1  at least one complete line is buffered.
REQ-015 rd_line_o  out  LW  slot index of the oldest complete line.
REQ-016 busy_o  out  1  host must not write; buffer full.
REQ-017 frame_rst_o  out  1  new frame started; host restarts its line count.
REQ-018 frame_line_o  out  FW  lines committed in the current frame.
REQ-019 ovf_o  out  1  sticky: a byte was dropped.

Function
REQ-020 smi_nwe_i and frame_opto_i SHALL each pass a 3-flop chain (s1, s2, s3); edge detection uses s2 against s3.
REQ-021 data_q SHALL load smi_data_i on every clk_i cycle in which nwe s1 is low.
REQ-022 A write event SHALL be nwe s2 high with s3 low; ram_we_o SHALL assert on the next cycle, with ram_wdata_o = data_q.
REQ-023 Pin-rise to ram_we_o latency SHALL be 3-4 clk_i cycles; smi_nwe_i low time of at least 2 clk_i periods is a usage requirement.
REQ-024 ram_waddr_o SHALL be {wr_line, byte_idx}; byte_idx increments after each write; wr_line changes only at line commit.
REQ-025 A write with byte_idx = LEDS*4-1 SHALL commit the line: byte_idx <= 0, wr_line <= wr_line+1 mod FIFO_LINES, count+1, frame_line+1 (saturating at LINES).
REQ-026 count (0..FIFO_LINES) SHALL decrement on line_pop_i when count != 0; rd_line SHALL then increment mod FIFO_LINES.
REQ-027 Commit and pop in the same cycle: count unchanged, both pointers advance.
REQ-028 line_pop_i with count = 0 SHALL be ignored.
REQ-029 busy_o SHALL be registered high when count = FIFO_LINES and low otherwise; line_valid_o = (count != 0).
REQ-030 A write event while count = FIFO_LINES SHALL be dropped: no ram_we_o, no pointer change, ovf_o set.
REQ-031 A write event while frame_line = LINES SHALL be dropped and ovf_o set.
REQ-032 A frame edge (opto s2 high, s3 low) SHALL do all of the following:
  - byte_idx <= 0, discarding any partial line;
  - frame_line <= 0 and ovf_o <= 0;
  - frame_rst_o <= 1.
  Committed lines and count are kept.
REQ-033 frame_rst_o SHALL clear on the cycle after the first accepted write of the new frame.
REQ-034 A frame edge coinciding with a write event: the frame edge is applied first, and the byte is accepted as byte 0 of the new frame.

Reset
REQ-035 While global_rst_n is low, all outputs SHALL be 0, except frame_rst_o = 1.
REQ-036 While global_rst_n is low, all pointers, counters and synchronizer flops SHALL be 0, with nwe s1-s3 at 1.
REQ-037 After release, the first write event SHALL require a genuine low-to-high sequence on smi_nwe_i.

Verification
REQ-038 Reset, then 192 bytes 0x01..0xC0 -> 192 ram_we_o pulses at addr 0x000..0x0BF with matching data; line_valid_o=1, rd_line_o=0, frame_line_o=1, frame_rst_o cleared after byte 1.
REQ-039 4 full lines with no pops -> busy_o=1; 5th-line byte -> no ram_we_o, ovf_o=1.
REQ-040 After REQ-039, one line_pop_i -> busy_o=0, rd_line_o=1; next byte written at addr {0,0}.
REQ-041 100 bytes, then frame_opto_i pulse -> frame_rst_o=1, ovf_o=0, frame_line_o=0; next byte at byte_idx 0 of the same wr_line.
REQ-042 line_pop_i in the same cycle as a line commit, with count=2 -> count stays 2, both pointers advance.
REQ-043 global_rst_n low mid-line -> outputs per REQ-035 immediately; post-reset writes start at addr 0.
